// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg
//    Shared definitions for the MEM/WB slice of the pipeline. It holds the
//    ld_type encodings used by the decoder and by the load extraction
//    logic, and a helper that says whether an encoding is a real load.
package mem_wb_pipe_pkg;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_W    = 3'd1;
   localparam logic [2:0] LD_B    = 3'd2;
   localparam logic [2:0] LD_BU   = 3'd3;
   localparam logic [2:0] LD_H    = 3'd4;
   localparam logic [2:0] LD_HU   = 3'd5;

   // Encodings 6 and 7 are reserved and behave like LD_NONE.
   function automatic logic is_load(input logic [2:0] ld_type);
      logic res;
      case (ld_type)
         LD_W, LD_B, LD_BU, LD_H, LD_HU: res = 1'b1;
         default:                        res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_wb_pipe_load_ext.sv
// load_ext
//    Combinational load-data extraction from a raw aligned memory word.
//    Ports:
//       mem_rdata (DW) : aligned data-memory word
//       addr_lo   (2)  : byte offset of the load address
//       ld_type   (3)  : load kind (see mem_wb_pipe_pkg)
//       load_data (DW) : extracted, sign/zero-extended result
//                        (0 when ld_type is not a load)
module load_ext
   import mem_wb_pipe_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] mem_rdata,
   input  logic [1:0]    addr_lo,
   input  logic [2:0]    ld_type,
   output logic [DW-1:0] load_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte/halfword and extend it according to the load kind.
   always_comb begin
      byte_s    = mem_rdata[{addr_lo, 3'b000} +: 8];
      // Halfword loads only look at addr_lo[1]; the odd offset bit is ignored.
      half_s    = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
      load_data = '0;
      case (ld_type)
         LD_W:    load_data = mem_rdata;
         LD_B:    load_data = {{(DW-8){byte_s[7]}}, byte_s};
         LD_BU:   load_data = {{(DW-8){1'b0}}, byte_s};
         LD_H:    load_data = {{(DW-16){half_s[15]}}, half_s};
         LD_HU:   load_data = {{(DW-16){1'b0}}, half_s};
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe
//    MEM/WB pipeline register with load-data extraction and a counter of
//    retired (valid) instructions.
//    Ports:
//       clk, reset           : clock, synchronous active-high reset
//       stall, flush         : hold the stage / load a bubble (flush wins)
//       in_valid             : MEM slot holds a real instruction
//       pc, ir, alu_out      : MEM-stage PC, instruction, ALU result
//       mem_rdata, addr_lo   : raw memory word and byte offset of the load
//       ld_type, wa, reg_we  : load kind, destination register, write enable
//       cp0_we               : CP0 write or eret
//       wb_*                 : registered WB-stage outputs
//       fwd_wd               : combinational write data for MEM forwarding
//       retired              : count of valid instructions entering WB
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int              DW     = 32,
   parameter int              AW     = 5,
   parameter int              CNT_W  = 32,
   parameter logic [DW-1:0]   PC_RST = 32'h0000_3000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [DW-1:0]    pc,
   input  logic [DW-1:0]    ir,
   input  logic [DW-1:0]    alu_out,
   input  logic [DW-1:0]    mem_rdata,
   input  logic [1:0]       addr_lo,
   input  logic [2:0]       ld_type,
   input  logic [AW-1:0]    wa,
   input  logic             reg_we,
   input  logic             cp0_we,
   output logic             wb_valid,
   output logic [DW-1:0]    wb_pc,
   output logic [DW-1:0]    wb_ir,
   output logic [DW-1:0]    wb_wd,
   output logic [AW-1:0]    wb_wa,
   output logic             wb_we,
   output logic             wb_cp0_we,
   output logic [DW-1:0]    fwd_wd,
   output logic [CNT_W-1:0] retired
);

   logic [DW-1:0]    load_data_s;
   logic [DW-1:0]    wd_s;

   logic             valid_d,  valid_q;
   logic [DW-1:0]    pc_d,     pc_q;
   logic [DW-1:0]    ir_d,     ir_q;
   logic [DW-1:0]    wd_d,     wd_q;
   logic [AW-1:0]    wa_d,     wa_q;
   logic             we_d,     we_q;
   logic             cp0_we_d, cp0_we_q;
   logic [CNT_W-1:0] ret_d,    ret_q;

   load_ext #(.DW(DW)) u_load_ext (
      .mem_rdata (mem_rdata),
      .addr_lo   (addr_lo),
      .ld_type   (ld_type),
      .load_data (load_data_s)
   );

   assign wd_s   = is_load(ld_type) ? load_data_s : alu_out;
   assign fwd_wd = wd_s;

   // Next-state selection with priority reset > flush > stall > load.
   always_comb begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      wd_d     = wd_q;
      wa_d     = wa_q;
      we_d     = we_q;
      cp0_we_d = cp0_we_q;
      ret_d    = ret_q;
      if (reset) begin
         valid_d  = 1'b0;
         pc_d     = PC_RST;
         ir_d     = '0;
         wd_d     = '0;
         wa_d     = '0;
         we_d     = 1'b0;
         cp0_we_d = 1'b0;
         ret_d    = '0;
      end else if (flush) begin
         // Bubble: everything cleared, counter untouched.
         valid_d  = 1'b0;
         pc_d     = '0;
         ir_d     = '0;
         wd_d     = '0;
         wa_d     = '0;
         we_d     = 1'b0;
         cp0_we_d = 1'b0;
      end else if (stall) begin
         valid_d  = valid_q;
      end else begin
         valid_d  = in_valid;
         pc_d     = pc;
         ir_d     = ir;
         wd_d     = wd_s;
         wa_d     = wa;
         // A write to $0 is never presented as a write.
         we_d     = reg_we & in_valid & (wa != '0);
         cp0_we_d = cp0_we & in_valid;
         if (in_valid) begin
            ret_d = ret_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            ret_d = ret_q;
         end
      end
   end

   // Pipeline register and retired counter.
   always_ff @(posedge clk) begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      wd_q     <= wd_d;
      wa_q     <= wa_d;
      we_q     <= we_d;
      cp0_we_q <= cp0_we_d;
      ret_q    <= ret_d;
   end

   assign wb_valid  = valid_q;
   assign wb_pc     = pc_q;
   assign wb_ir     = ir_q;
   assign wb_wd     = wd_q;
   assign wb_wa     = wa_q;
   assign wb_we     = we_q;
   assign wb_cp0_we = cp0_we_q;
   assign retired   = ret_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;

   logic        clk = 1'b0;
   logic        reset, stall, flush, in_valid, reg_we, cp0_we;
   logic [31:0] pc, ir, alu_out, mem_rdata;
   logic [1:0]  addr_lo;
   logic [2:0]  ld_type;
   logic [4:0]  wa;

   logic        wb_valid, wb_we, wb_cp0_we;
   logic [31:0] wb_pc, wb_ir, wb_wd, fwd_wd, retired;
   logic [4:0]  wb_wa;

   logic        w4_valid, w4_we, w4_cp0_we;
   logic [31:0] w4_pc, w4_ir, w4_wd, w4_fwd;
   logic [4:0]  w4_wa;
   logic [3:0]  retired4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_wb_pipe dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .pc(pc), .ir(ir), .alu_out(alu_out), .mem_rdata(mem_rdata), .addr_lo(addr_lo),
      .ld_type(ld_type), .wa(wa), .reg_we(reg_we), .cp0_we(cp0_we),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ir(wb_ir), .wb_wd(wb_wd), .wb_wa(wb_wa),
      .wb_we(wb_we), .wb_cp0_we(wb_cp0_we), .fwd_wd(fwd_wd), .retired(retired)
   );

   mem_wb_pipe #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .pc(pc), .ir(ir), .alu_out(alu_out), .mem_rdata(mem_rdata), .addr_lo(addr_lo),
      .ld_type(ld_type), .wa(wa), .reg_we(reg_we), .cp0_we(cp0_we),
      .wb_valid(w4_valid), .wb_pc(w4_pc), .wb_ir(w4_ir), .wb_wd(w4_wd), .wb_wa(w4_wa),
      .wb_we(w4_we), .wb_cp0_we(w4_cp0_we), .fwd_wd(w4_fwd), .retired(retired4)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference write data computed by shifting and arithmetic, not bit slicing.
   function automatic logic [31:0] ref_wd(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] t, input logic [31:0] alu);
      logic [31:0] b, h;
      b = (w >> (8 * a)) & 32'h0000_00FF;
      h = (w >> (16 * (a / 2))) & 32'h0000_FFFF;
      case (t)
         3'd1:    return w;
         3'd2:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd3:    return b;
         3'd4:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd5:    return h;
         default: return alu;
      endcase
   endfunction

   // Behavioural model of the WB stage contents.
   logic        m_ok = 1'b0;
   logic        m_valid, m_we, m_cp0;
   logic [31:0] m_pc, m_ir, m_wd;
   logic [4:0]  m_wa;
   longint      m_count;

   always @(posedge clk) begin
      if (reset) begin
         m_ok <= 1'b1;
         {m_valid, m_we, m_cp0} <= 3'b000;
         m_pc <= 32'h0000_3000; m_ir <= 32'd0; m_wd <= 32'd0; m_wa <= 5'd0;
         m_count <= 0;
      end else if (flush) begin
         {m_valid, m_we, m_cp0} <= 3'b000;
         m_pc <= 32'd0; m_ir <= 32'd0; m_wd <= 32'd0; m_wa <= 5'd0;
      end else if (!stall) begin
         m_valid <= in_valid;
         m_pc <= pc; m_ir <= ir; m_wa <= wa;
         m_wd <= ref_wd(mem_rdata, addr_lo, ld_type, alu_out);
         m_we <= reg_we && in_valid && wa != 5'd0;
         m_cp0 <= cp0_we && in_valid;
         if (in_valid) m_count <= m_count + 1;
      end
   end

   // Compare every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("wb_valid", 64'(wb_valid), 64'(m_valid));
         chk("wb_pc", 64'(wb_pc), 64'(m_pc));
         chk("wb_ir", 64'(wb_ir), 64'(m_ir));
         chk("wb_wd", 64'(wb_wd), 64'(m_wd));
         chk("wb_wa", 64'(wb_wa), 64'(m_wa));
         chk("wb_we", 64'(wb_we), 64'(m_we));
         chk("wb_cp0_we", 64'(wb_cp0_we), 64'(m_cp0));
         chk("retired", 64'(retired), 64'(m_count % 64'h1_0000_0000));
         chk("retired4", 64'(retired4), 64'(m_count % 16));
         chk("fwd_wd", 64'(fwd_wd), 64'(ref_wd(mem_rdata, addr_lo, ld_type, alu_out)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i,
                        input logic [31:0] alu, input logic [31:0] md, input logic [1:0] a,
                        input logic [2:0] t, input logic [4:0] w, input logic rw, input logic c);
      in_valid = v; pc = p; ir = i; alu_out = alu; mem_rdata = md;
      addr_lo = a; ld_type = t; wa = w; reg_we = rw; cp0_we = c;
   endtask

   initial begin
      // Reset together with stall and flush.
      reset = 1'b1; stall = 1'b1; flush = 1'b1;
      drive(1'b1, 32'h100, 32'h1111, 32'h55, 32'hFFFF_FFFF, 2'd0, 3'd1, 5'd3, 1'b1, 1'b1);
      tick(); tick();
      chk("rst_pc", 64'(wb_pc), 64'h3000);
      chk("rst_zero", 64'({wb_valid, wb_we, wb_cp0_we, wb_ir, wb_wd, wb_wa}), 64'd0);
      chk("rst_ret", 64'(retired), 64'd0);
      reset = 1'b0; stall = 1'b0; flush = 1'b0;

      drive(1'b1, 32'h104, 32'hA1, 32'h0, 32'h8899_AABB, 2'd1, 3'd2, 5'd5, 1'b1, 1'b0);
      tick();
      chk("lb", 64'(wb_wd), 64'hFFFF_FFAA);
      chk("lb_we", 64'({wb_valid, wb_we}), 64'd3);
      chk("ret1", 64'(retired), 64'd1);
      ld_type = 3'd3; tick();
      chk("lbu", 64'(wb_wd), 64'h0000_00AA);
      addr_lo = 2'd2; ld_type = 3'd4; tick();
      chk("lh", 64'(wb_wd), 64'hFFFF_8899);
      addr_lo = 2'd3; ld_type = 3'd5; tick();
      chk("lhu_odd", 64'(wb_wd), 64'h0000_8899);
      ld_type = 3'd1; tick();
      chk("lw", 64'(wb_wd), 64'h8899_AABB);
      ld_type = 3'd0; alu_out = 32'h1234; tick();
      chk("none", 64'(wb_wd), 64'h1234);
      ld_type = 3'd7; alu_out = 32'h5678; tick();
      chk("ld7", 64'(wb_wd), 64'h5678);

      // $0 write suppressed, still retires.
      drive(1'b1, 32'h108, 32'hA2, 32'h9, 32'h0, 2'd0, 3'd0, 5'd0, 1'b1, 1'b1);
      tick();
      chk("wa0_we", 64'(wb_we), 64'd0);
      chk("wa0_ret", 64'(retired), 64'd8);
      chk("cp0", 64'(wb_cp0_we), 64'd1);
      // Invalid slot: no retire, no CP0 write.
      in_valid = 1'b0; wa = 5'd4; tick();
      chk("inv_cp0", 64'({wb_valid, wb_cp0_we, wb_we}), 64'd0);
      chk("inv_ret", 64'(retired), 64'd8);

      // Load a valid instruction, then stall with changing inputs.
      drive(1'b1, 32'h200, 32'hBEEF, 32'h77, 32'h0, 2'd0, 3'd0, 5'd9, 1'b1, 1'b0);
      tick();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h300 + 32'(k), 32'hC0 + 32'(k), 32'h1 + 32'(k), 32'h0,
               2'd0, 3'd0, 5'd10, 1'b1, 1'b1);
         tick();
         chk("stall_pc", 64'(wb_pc), 64'h200);
         chk("stall_wd", 64'(wb_wd), 64'h77);
         chk("stall_ret", 64'(retired), 64'd9);
      end
      flush = 1'b1; tick();
      chk("flush_valid", 64'(wb_valid), 64'd0);
      chk("flush_pc", 64'(wb_pc), 64'd0);
      chk("flush_ret", 64'(retired), 64'd9);

      // Reset mid-stall with flush.
      reset = 1'b1; tick();
      chk("rst2_pc", 64'(wb_pc), 64'h3000);
      chk("rst2_ret", 64'({retired, 4'(retired4)}), 64'd0);
      reset = 1'b0; stall = 1'b0; flush = 1'b0;

      // 17 valid loads on the 4-bit counter instance.
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, 32'h400 + 32'(4 * k), 32'(k), 32'(k), 32'h0, 2'd0, 3'd0, 5'd1, 1'b1, 1'b0);
         tick();
      end
      chk("wrap4", 64'(retired4), 64'd1);
      chk("ret17", 64'(retired), 64'd17);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DW, default 32: data, PC and IR width.
REQ-002 SHALL have parameter AW, default 5: register-file address width.
REQ-003 SHALL have parameter CNT_W, default 32: retired-instruction counter width.
REQ-004 SHALL have parameter PC_RST, default 32'h0000_3000: wb_pc value after reset.
REQ-005 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have inputs stall (1: hold stage), flush (1: insert bubble) and in_valid (1: MEM slot holds a real instruction).
REQ-008 SHALL have inputs pc (DW), ir (DW), alu_out (DW) and mem_rdata (DW): raw aligned data-memory word.
REQ-009 SHALL have inputs addr_lo (2: byte offset of the load address), ld_type (3: 0 none, 1 lw, 2 lb, 3 lbu, 4 lh, 5 lhu; 6-7 treated as none), wa (AW), reg_we (1) and cp0_we (1: CP0 write or eret).
REQ-010 SHALL have outputs wb_valid (1), wb_pc (DW), wb_ir (DW), wb_wd (DW), wb_wa (AW), wb_we (1) and wb_cp0_we (1).
REQ-011 SHALL have output fwd_wd (DW): combinational next-cycle write data, for MEM-stage forwarding.
REQ-012 SHALL have output retired (CNT_W): count of valid instructions that entered WB.

Function
REQ-013 SHALL compute the load result combinationally from mem_rdata and addr_lo:
  - lb/lbu: byte addr_lo, sign- or zero-extended to DW.
  - lh/lhu: halfword addr_lo[1], sign- or zero-extended; addr_lo[0] ignored.
  - lw: whole word.
REQ-014 SHALL select the load result as write data when ld_type is 1-5, otherwise alu_out; fwd_wd SHALL equal this value.
REQ-015 SHALL apply per-edge priority reset > flush > stall > load.
REQ-016 On load, SHALL register pc, ir, the selected write data, wa, in_valid and cp0_we&in_valid.
REQ-017 On load, wb_we SHALL be reg_we & in_valid & (wa != 0), so a $0 write never appears as a write.
REQ-018 On stall without flush, SHALL hold every output register unchanged.
REQ-019 On flush, SHALL load a bubble: wb_valid, wb_we and wb_cp0_we 0; wb_ir, wb_wd, wb_wa and wb_pc 0.
REQ-020 On load, retired SHALL increment by 1 when in_valid=1 and SHALL wrap modulo 2^CNT_W.
REQ-021 retired SHALL NOT increment on stall, flush or load with in_valid=0.
REQ-022 When stall and flush are both 1, flush SHALL win.
REQ-023 Output latency SHALL be exactly one cycle from the MEM-side inputs to the wb_* outputs.

Reset
REQ-024 On reset, SHALL clear wb_valid, wb_we, wb_cp0_we, wb_ir, wb_wd, wb_wa and retired to 0, and SHALL set wb_pc to PC_RST.
REQ-025 Reset asserted mid-stall or together with flush SHALL override both within the same edge.
REQ-026 SHALL contain no initial blocks; reset is the only initialisation.

Structure
REQ-027 The ld_type encodings (LD_NONE, LD_W, LD_B, LD_BU, LD_H, LD_HU) SHALL be shared constants in the shared definitions header, also used by the decoder.
REQ-028 Load extraction SHALL be one combinational sub-module, load_ext: inputs mem_rdata, addr_lo, ld_type; output load data.
REQ-029 The pipeline register and retired counter SHALL reside in mem_wb_pipe.

Verification
REQ-030 Bench SHALL cover: mem_rdata=32'h8899_AABB, addr_lo=1, ld_type=lb -> next cycle wb_wd=32'hFFFF_FFAA; with lbu -> 32'h0000_00AA.
REQ-031 Bench SHALL cover: same word, addr_lo=2, ld_type=lh -> 32'hFFFF_8899; ld_type=none with alu_out=32'h1234 -> wb_wd=32'h1234.
REQ-032 Bench SHALL cover: reg_we=1, wa=0, in_valid=1 -> wb_we=0 and retired increments by 1.
REQ-033 Bench SHALL cover: load valid instruction, then stall=1 for 3 cycles with changing inputs -> outputs frozen and retired unchanged; then stall=1, flush=1 -> bubble, wb_valid=0.
REQ-034 Bench SHALL cover: reset asserted with flush=1 and stall=1 -> wb_pc=32'h0000_3000, all other outputs 0.
REQ-035 Bench SHALL cover: CNT_W=4, 17 valid loads -> retired=1, checking wrap-around.
